// File: rtl/sequenciador_controle.sv
// Multi-cycle fetch/decode/execute control sequencer for the 8-bit processor.
// Outputs are decoded combinationally from the state register, IR and the registered flags.
module sequenciador_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_result,
  output logic [1:0] bus1_sel,
  output logic [1:0] bus2_sel,
  output logic [3:0] alu_sel,
  output logic       PC_load,
  output logic       PC_inc,
  output logic       MAR_load,
  output logic       IR_load,
  output logic       A_load,
  output logic       B_load,
  output logic       CCR_load,
  output logic       write,
  output logic       halted,
  output logic       instr_fim
);

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD     = 8'h42;
  localparam logic [7:0] OP_SUB     = 8'h43;
  localparam logic [7:0] OP_AND     = 8'h44;
  localparam logic [7:0] OP_OR      = 8'h45;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BEQ     = 8'h23;
  localparam logic [7:0] OP_BCS     = 8'h24;
  localparam logic [7:0] OP_BVS     = 8'h25;
  localparam logic [7:0] OP_HLT     = 8'hFF;

  localparam logic [1:0] B1_PC   = 2'b00;
  localparam logic [1:0] B1_A    = 2'b01;
  localparam logic [1:0] B1_B    = 2'b10;
  localparam logic [1:0] B2_ALU  = 2'b00;
  localparam logic [1:0] B2_BUS1 = 2'b01;
  localparam logic [1:0] B2_MEM  = 2'b10;

  typedef enum logic [3:0] {
    S_F0   = 4'd0,
    S_F1   = 4'd1,
    S_F2   = 4'd2,
    S_D3   = 4'd3,
    S_4    = 4'd4,
    S_5    = 4'd5,
    S_6    = 4'd6,
    S_7    = 4'd7,
    S_8    = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_NOP     = 4'd0,
    C_LDA_IMM = 4'd1,
    C_LDB_IMM = 4'd2,
    C_LDA_DIR = 4'd3,
    C_LDB_DIR = 4'd4,
    C_STA     = 4'd5,
    C_STB     = 4'd6,
    C_ALU     = 4'd7,
    C_BR      = 4'd8,
    C_HLT     = 4'd9
  } cls_t;

  state_t     r_state;
  state_t     w_next;
  cls_t       w_cls;
  logic [3:0] w_alu_code;
  logic       w_taken;

  // Opcode classification; anything not in the map behaves as NOP.
  always_comb begin
    w_cls      = C_NOP;
    w_alu_code = 4'd0;
    w_taken    = 1'b0;
    case (IR)
      OP_LDA_IMM: w_cls = C_LDA_IMM;
      OP_LDB_IMM: w_cls = C_LDB_IMM;
      OP_LDA_DIR: w_cls = C_LDA_DIR;
      OP_LDB_DIR: w_cls = C_LDB_DIR;
      OP_STA_DIR: w_cls = C_STA;
      OP_STB_DIR: w_cls = C_STB;
      OP_ADD:     begin w_cls = C_ALU; w_alu_code = 4'd0; end
      OP_SUB:     begin w_cls = C_ALU; w_alu_code = 4'd1; end
      OP_AND:     begin w_cls = C_ALU; w_alu_code = 4'd2; end
      OP_OR:      begin w_cls = C_ALU; w_alu_code = 4'd3; end
      OP_BRA:     begin w_cls = C_BR;  w_taken = 1'b1;          end
      OP_BMI:     begin w_cls = C_BR;  w_taken = CCR_result[3]; end
      OP_BEQ:     begin w_cls = C_BR;  w_taken = CCR_result[2]; end
      OP_BCS:     begin w_cls = C_BR;  w_taken = CCR_result[0]; end
      OP_BVS:     begin w_cls = C_BR;  w_taken = CCR_result[1]; end
      OP_HLT:     w_cls = C_HLT;
      OP_NOP:     w_cls = C_NOP;
      default:    w_cls = C_NOP;
    endcase
  end

  // State register with synchronous reset back to the first fetch step.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_F0;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_next    = S_F0;
    bus1_sel  = B1_PC;
    bus2_sel  = B2_ALU;
    alu_sel   = 4'd0;
    PC_load   = 1'b0;
    PC_inc    = 1'b0;
    MAR_load  = 1'b0;
    IR_load   = 1'b0;
    A_load    = 1'b0;
    B_load    = 1'b0;
    CCR_load  = 1'b0;
    write     = 1'b0;
    halted    = 1'b0;
    instr_fim = 1'b0;
    case (r_state)
      S_F0: begin
        bus1_sel = B1_PC;
        bus2_sel = B2_BUS1;
        MAR_load = 1'b1;
        w_next   = S_F1;
      end
      S_F1: begin
        PC_inc = 1'b1;
        w_next = S_F2;
      end
      S_F2: begin
        bus2_sel = B2_MEM;
        IR_load  = 1'b1;
        w_next   = S_D3;
      end
      S_D3: begin
        case (w_cls)
          C_NOP: begin
            instr_fim = 1'b1;
            w_next    = S_F0;
          end
          C_HLT:   w_next = S_HALT;
          default: w_next = S_4;
        endcase
      end
      S_4: begin
        case (w_cls)
          C_ALU: begin
            bus1_sel  = B1_B;
            bus2_sel  = B2_ALU;
            alu_sel   = w_alu_code;
            A_load    = 1'b1;
            CCR_load  = 1'b1;
            instr_fim = 1'b1;
            w_next    = S_F0;
          end
          C_NOP, C_HLT: w_next = S_F0;
          default: begin
            // Operand address comes from PC for loads, stores and branches alike.
            bus1_sel = B1_PC;
            bus2_sel = B2_BUS1;
            MAR_load = 1'b1;
            w_next   = S_5;
          end
        endcase
      end
      S_5: begin
        case (w_cls)
          C_BR: w_next = S_6;
          C_LDA_IMM, C_LDB_IMM, C_LDA_DIR, C_LDB_DIR, C_STA, C_STB: begin
            PC_inc = 1'b1;
            w_next = S_6;
          end
          default: w_next = S_F0;
        endcase
      end
      S_6: begin
        case (w_cls)
          C_LDA_IMM: begin
            bus2_sel  = B2_MEM;
            A_load    = 1'b1;
            instr_fim = 1'b1;
            w_next    = S_F0;
          end
          C_LDB_IMM: begin
            bus2_sel  = B2_MEM;
            B_load    = 1'b1;
            instr_fim = 1'b1;
            w_next    = S_F0;
          end
          C_LDA_DIR, C_LDB_DIR, C_STA, C_STB: begin
            bus2_sel = B2_MEM;
            MAR_load = 1'b1;
            w_next   = S_7;
          end
          C_BR: begin
            // Taken branch loads the target instead of skipping the operand byte.
            if (w_taken) begin
              bus2_sel = B2_MEM;
              PC_load  = 1'b1;
            end else begin
              PC_inc = 1'b1;
            end
            instr_fim = 1'b1;
            w_next    = S_F0;
          end
          default: w_next = S_F0;
        endcase
      end
      S_7: begin
        case (w_cls)
          C_STA: begin
            bus1_sel  = B1_A;
            write     = 1'b1;
            instr_fim = 1'b1;
            w_next    = S_F0;
          end
          C_STB: begin
            bus1_sel  = B1_B;
            write     = 1'b1;
            instr_fim = 1'b1;
            w_next    = S_F0;
          end
          C_LDA_DIR, C_LDB_DIR: w_next = S_8;
          default:              w_next = S_F0;
        endcase
      end
      S_8: begin
        case (w_cls)
          C_LDA_DIR: begin
            bus2_sel  = B2_MEM;
            A_load    = 1'b1;
            instr_fim = 1'b1;
          end
          C_LDB_DIR: begin
            bus2_sel  = B2_MEM;
            B_load    = 1'b1;
            instr_fim = 1'b1;
          end
          default: instr_fim = 1'b0;
        endcase
        w_next = S_F0;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_F0;
    endcase
  end

endmodule
